// File: rtl/wb_arbiter2.sv
// wb_arbiter2 - two-master / one-slave Wishbone B4 pipelined arbiter.
// Grants the slave per Wishbone cycle with round-robin priority, limits the
// number of accepted-but-unacknowledged transfers, and releases the bus as
// soon as the holding master drops cyc.
// Optional feature macro: WB_ARB_TIMEOUT_EN - adds an idle-ack watchdog that
// aborts a stuck cycle by returning one synthetic ack per outstanding
// transfer and raising the sticky timeout_o flag.
module wb_arbiter2 #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_stall_o,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_stall_o,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_stall_i,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o,
  input  logic        timeout_clr_i
);

  localparam logic [3:0]  MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
`ifdef WB_ARB_TIMEOUT_EN
    , ST_ABORT = 2'd3
`endif
  } state_t;

  state_t      state_r, state_s;
  logic        last_grant_r, last_grant_s;  // also identifies the current holder
  logic [3:0]  count_r, count_s;
  logic        hold_cyc_s;
  logic        full_s;
  logic        stb_s;
  logic        accept_s;
  logic        ack_dec_s;

  // cyc of the master that currently owns (or last owned) the bus
  assign hold_cyc_s = last_grant_r ? m1_cyc_i : m0_cyc_i;
  assign full_s     = (count_r == MAX_CNT);
  assign accept_s   = stb_s & ~s_stall_i;
  // an ack with nothing outstanding must not wrap the counter
  assign ack_dec_s  = s_ack_i & (count_r != 4'd0);
  assign s_stb_o    = stb_s;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [31:0] ABORT_DAT = 32'hDEAD_BEEF;

  logic [15:0] tmo_r, tmo_s;
  logic        timeout_r;
  logic        tmo_set_s;
  logic        abort_ack_s;

  assign abort_ack_s = hold_cyc_s & (count_r != 4'd0);
  assign timeout_o   = timeout_r;
`else
  logic unused_s;

  assign unused_s  = ^{timeout_clr_i, TMO_LAST};
  assign timeout_o = 1'b0;
`endif

  // Output steering: slave side muxed from the holder, acks/data routed back
  always_comb begin
    s_cyc_o    = 1'b0;
    stb_s      = 1'b0;
    s_we_o     = 1'b0;
    s_sel_o    = 4'd0;
    s_adr_o    = 32'd0;
    s_dat_o    = 32'd0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m0_dat_o   = 32'd0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_dat_o   = 32'd0;
    case (state_r)
      ST_GRANT0: begin
        s_cyc_o    = m0_cyc_i;
        stb_s      = m0_cyc_i & m0_stb_i & ~full_s;
        s_we_o     = m0_we_i;
        s_sel_o    = m0_sel_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        m0_stall_o = s_stall_i | full_s;
        m0_ack_o   = s_ack_i;
        m0_dat_o   = s_dat_i;
      end
      ST_GRANT1: begin
        s_cyc_o    = m1_cyc_i;
        stb_s      = m1_cyc_i & m1_stb_i & ~full_s;
        s_we_o     = m1_we_i;
        s_sel_o    = m1_sel_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        m1_stall_o = s_stall_i | full_s;
        m1_ack_o   = s_ack_i;
        m1_dat_o   = s_dat_i;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (last_grant_r) begin
          m1_ack_o = abort_ack_s;
          m1_dat_o = abort_ack_s ? ABORT_DAT : 32'd0;
        end else begin
          m0_ack_o = abort_ack_s;
          m0_dat_o = abort_ack_s ? ABORT_DAT : 32'd0;
        end
      end
`endif
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Next-state logic: arbitration, outstanding tracking, watchdog
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    count_s      = count_r;
`ifdef WB_ARB_TIMEOUT_EN
    tmo_s        = tmo_r;
    tmo_set_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        count_s = 4'd0;
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_grant_r) begin
            state_s      = ST_GRANT0;
            last_grant_s = 1'b0;
          end else begin
            state_s      = ST_GRANT1;
            last_grant_s = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_s      = ST_GRANT0;
          last_grant_s = 1'b0;
        end else if (m1_cyc_i) begin
          state_s      = ST_GRANT1;
          last_grant_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (!hold_cyc_s) begin
          // holder ended (or abandoned) its cycle: outstanding work is dropped
          state_s = ST_IDLE;
          count_s = 4'd0;
`ifdef WB_ARB_TIMEOUT_EN
          tmo_s   = 16'd0;
`endif
        end else begin
          count_s = count_r + {3'd0, accept_s} - {3'd0, ack_dec_s};
`ifdef WB_ARB_TIMEOUT_EN
          if (accept_s || s_ack_i || (count_r == 4'd0)) begin
            tmo_s = 16'd0;
          end else if (tmo_r == TMO_LAST) begin
            state_s   = ST_ABORT;
            tmo_s     = 16'd0;
            tmo_set_s = 1'b1;
          end else begin
            tmo_s = tmo_r + 16'd1;
          end
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!hold_cyc_s) begin
          state_s = ST_IDLE;
          count_s = 4'd0;
        end else if (count_r <= 4'd1) begin
          // last synthetic ack this cycle: hand the bus back to the holder
          state_s = last_grant_r ? ST_GRANT1 : ST_GRANT0;
          count_s = 4'd0;
        end else begin
          count_s = count_r - 4'd1;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
        count_s = 4'd0;
      end
    endcase
  end

  // State, grant history and outstanding-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      count_r      <= 4'd0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      count_r      <= count_s;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_r     <= 16'd0;
      timeout_r <= 1'b0;
    end else begin
      tmo_r <= tmo_s;
      if (tmo_set_s) begin
        timeout_r <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_r <= 1'b0;
      end else begin
        timeout_r <= timeout_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the arbitration and outstanding-transfer rules.
module tb_wb_arbiter2;

  localparam int MAX_OUT = 4;
  localparam int TMO     = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [3:0]  m0_sel_i = 4'd0;
  logic [31:0] m0_adr_i = 32'd0, m0_dat_i = 32'd0;
  logic        m0_stall_o, m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m1_sel_i = 4'd0;
  logic [31:0] m1_adr_i = 32'd0, m1_dat_i = 32'd0;
  logic        m1_stall_o, m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_stall_i = 1'b0, s_ack_i = 1'b0;
  logic [31:0] s_dat_i = 32'd0;
  logic        timeout_o;
  logic        timeout_clr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_hold = -1;   // master owning the bus, -1 when idle
  int m_last = 1;    // most recent grant
  int m_out  = 0;    // accepted but unacknowledged transfers
  bit m_abort = 1'b0;
  bit m_tflag = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
  int m_idle = 0;
`endif

  wb_arbiter2 #(.MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
    .s_dat_i(s_dat_i), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // end of a cycle: inputs for the next one are driven 1 time unit after the edge
  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic count_acc(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      #2;
      if (s_stb_o && !s_stall_i) n++;
      cyc_end();
    end
  endtask

  // Model-based compare of every output, every cycle, then model update
  always @(negedge clk) begin : model_cmp
    logic e_cyc, e_stb, e_we;
    logic [3:0] e_sel;
    logic [31:0] e_adr, e_sdat;
    logic e_stall [2];
    logic e_ack [2];
    logic [31:0] e_mdat [2];
    logic hc, h_stb, full, acc, ackd, set_now;

    if (!rst_n) begin
      m_hold = -1; m_last = 1; m_out = 0; m_abort = 1'b0; m_tflag = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      m_idle = 0;
`endif
    end
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'd0; e_adr = 32'd0; e_sdat = 32'd0;
    for (int k = 0; k < 2; k++) begin
      e_stall[k] = 1'b1; e_ack[k] = 1'b0; e_mdat[k] = 32'd0;
    end
    hc    = (m_hold == 1) ? m1_cyc_i : m0_cyc_i;
    h_stb = (m_hold == 1) ? m1_stb_i : m0_stb_i;
    full  = (m_out == MAX_OUT);
    if (m_hold >= 0 && !m_abort) begin
      e_cyc  = hc;
      e_stb  = hc && h_stb && !full;
      e_we   = (m_hold == 1) ? m1_we_i  : m0_we_i;
      e_sel  = (m_hold == 1) ? m1_sel_i : m0_sel_i;
      e_adr  = (m_hold == 1) ? m1_adr_i : m0_adr_i;
      e_sdat = (m_hold == 1) ? m1_dat_i : m0_dat_i;
      e_stall[m_hold] = s_stall_i || full;
      e_ack[m_hold]   = s_ack_i;
      e_mdat[m_hold]  = s_dat_i;
    end else if (m_abort) begin
      e_ack[m_hold]  = hc && (m_out > 0);
      e_mdat[m_hold] = e_ack[m_hold] ? 32'hDEAD_BEEF : 32'd0;
    end

    chk("s_ctl", {25'd0, s_cyc_o, s_stb_o, s_we_o, s_sel_o}, {25'd0, e_cyc, e_stb, e_we, e_sel});
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", s_dat_o, e_sdat);
    chk("m0_ctl", {30'd0, m0_stall_o, m0_ack_o}, {30'd0, e_stall[0], e_ack[0]});
    chk("m0_dat", m0_dat_o, e_mdat[0]);
    chk("m1_ctl", {30'd0, m1_stall_o, m1_ack_o}, {30'd0, e_stall[1], e_ack[1]});
    chk("m1_dat", m1_dat_o, e_mdat[1]);
    chk("timeout", {31'd0, timeout_o}, {31'd0, m_tflag});

    if (rst_n) begin
      set_now = 1'b0;
      if (m_hold < 0) begin
        if (m0_cyc_i && m1_cyc_i) m_hold = 1 - m_last;
        else if (m0_cyc_i) m_hold = 0;
        else if (m1_cyc_i) m_hold = 1;
        if (m_hold >= 0) m_last = m_hold;
        m_out = 0;
      end else if (!m_abort) begin
        if (!hc) begin
          m_hold = -1;
          m_out  = 0;
`ifdef WB_ARB_TIMEOUT_EN
          m_idle = 0;
`endif
        end else begin
          acc  = e_stb && !s_stall_i;
          ackd = s_ack_i && (m_out > 0);
`ifdef WB_ARB_TIMEOUT_EN
          if (acc || s_ack_i || m_out == 0) begin
            m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle == TMO) begin
              m_abort = 1'b1; m_idle = 0; set_now = 1'b1;
            end
          end
`endif
          m_out = m_out + int'(acc) - int'(ackd);
        end
      end else begin
        if (!hc) begin
          m_hold = -1; m_out = 0; m_abort = 1'b0;
        end else begin
          m_out--;
          if (m_out == 0) m_abort = 1'b0;
        end
      end
      if (set_now) m_tflag = 1'b1;
      else if (timeout_clr_i) m_tflag = 1'b0;
    end
  end

  int n;
  int quiet;
`ifdef WB_ARB_TIMEOUT_EN
  int first, nack, bad;
`endif

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    #2;
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_stalls", {30'd0, m0_stall_o, m1_stall_o}, 32'd3);
    chk("rst_acks", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
    cyc_end();
    rst_n = 1'b1;
    #2; cyc_end();

    // single master read, slave acks 2 cycles after accept
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_adr_i = 32'h8000_0000;
    #2; chk("a_not_yet", {31'd0, s_cyc_o}, 32'd0); cyc_end();
    #2;
    chk("a_grant", {30'd0, s_cyc_o, m0_stall_o}, 32'd2);
    chk("a_adr", s_adr_o, 32'h8000_0000);
    chk("a_m1_stall", {31'd0, m1_stall_o}, 32'd1);
    cyc_end();
    m0_stb_i = 1'b0;
    #2; cyc_end();
    s_ack_i = 1'b1; s_dat_i = 32'h1234_5678;
    #2;
    chk("a_ack", {31'd0, m0_ack_o}, 32'd1);
    chk("a_dat", m0_dat_o, 32'h1234_5678);
    chk("a_m1_stall2", {31'd0, m1_stall_o}, 32'd1);
    cyc_end();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();

    // contention after reset, then round-robin
    rst_n = 1'b0; #2; cyc_end(); #2; cyc_end();
    rst_n = 1'b1; #2; cyc_end();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    #2; cyc_end();
    #2; chk("b_first_m0", {29'd0, s_cyc_o, m0_stall_o, m1_stall_o}, 32'd5); cyc_end();
    m0_cyc_i = 1'b0;
    #2; chk("b_drop", {31'd0, s_cyc_o}, 32'd0); cyc_end();
    #2; chk("b_gap", {30'd0, s_cyc_o, m1_stall_o}, 32'd1); cyc_end();
    #2; chk("b_m1", {29'd0, s_cyc_o, m0_stall_o, m1_stall_o}, 32'd6); cyc_end();
    m1_cyc_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    #2; cyc_end();
    #2; chk("b_rr_m0", {29'd0, s_cyc_o, m0_stall_o, m1_stall_o}, 32'd5); cyc_end();
    m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();

    // outstanding limit with acks held off
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    #2; cyc_end();
    count_acc(6, n);
    chk("c_accepts", n, 32'd4);
    #2; chk("c_full_stall", {30'd0, m0_stall_o, s_stb_o}, 32'd2); cyc_end();
    s_ack_i = 1'b1;
    #2; chk("c_ack_stall", {31'd0, m0_stall_o}, 32'd1); cyc_end();
    s_ack_i = 1'b0;
    #2; chk("c_release", {30'd0, m0_stall_o, s_stb_o}, 32'd1); cyc_end();
    #2; chk("c_refull", {31'd0, m0_stall_o}, 32'd1); cyc_end();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();

    // simultaneous accept+ack at count 2 keeps the count
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #2; cyc_end();
    count_acc(2, n);
    s_ack_i = 1'b1;
    #2; chk("d_both", {30'd0, s_stb_o, s_stall_i}, 32'd2); cyc_end();
    s_ack_i = 1'b0;
    count_acc(4, n);
    chk("d_simul", n, 32'd2);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();
    // ack at count 0 is routed but does not underflow
    m0_cyc_i = 1'b1;
    #2; cyc_end();
    s_ack_i = 1'b1;
    #2; chk("d_ack0", {31'd0, m0_ack_o}, 32'd1); cyc_end();
    s_ack_i = 1'b0; m0_stb_i = 1'b1;
    count_acc(6, n);
    chk("d_no_underflow", n, 32'd4);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();

    // asynchronous reset mid-burst with 2 outstanding
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0040;
    #2; cyc_end();
    count_acc(2, n);
    m0_stb_i = 1'b0;
    #2; rst_n = 1'b0; #1;
    chk("e_rst_ctl", {28'd0, s_cyc_o, s_stb_o, m0_stall_o, m0_ack_o}, 32'd2);
    chk("e_rst_adr", s_adr_o, 32'd0);
    cyc_end();
    m0_cyc_i = 1'b0; s_ack_i = 1'b1;
    #2; cyc_end();
    rst_n = 1'b1;
    #2; chk("e_late_ack", {31'd0, m0_ack_o}, 32'd0); cyc_end();
    s_ack_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #2; cyc_end();
    count_acc(6, n);
    chk("e_count_zero", n, 32'd4);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: 3 writes never acknowledged
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
    #2; cyc_end();
    count_acc(3, n);
    m0_stb_i = 1'b0;
    first = -1; nack = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (m0_ack_o) begin
        if (first < 0) first = i;
        nack++;
        if (m0_dat_o !== 32'hDEAD_BEEF) bad++;
      end
      cyc_end();
    end
    chk("f_first_ack", first, 32'd8);
    chk("f_ack_count", nack, 32'd3);
    chk("f_bad_dat", bad, 32'd0);
    chk("f_flag", {31'd0, timeout_o}, 32'd1);
    timeout_clr_i = 1'b1;
    #2; cyc_end();
    timeout_clr_i = 1'b0;
    #2; chk("f_clr", {31'd0, timeout_o}, 32'd0); cyc_end();
    m0_cyc_i = 1'b0;
    #2; cyc_end(); #2; cyc_end();
`endif

    // randomized traffic, checked by the model every cycle
    quiet = 0;
    for (int c = 0; c < 4000; c++) begin
      m0_cyc_i = m0_cyc_i ? (($urandom % 16) != 0) : (($urandom % 4) == 0);
      m1_cyc_i = m1_cyc_i ? (($urandom % 16) != 0) : (($urandom % 4) == 0);
      m0_stb_i = ($urandom % 4) != 0;
      m1_stb_i = ($urandom % 4) != 0;
      m0_we_i  = 1'($urandom);
      m1_we_i  = 1'($urandom);
      m0_sel_i = 4'($urandom);
      m1_sel_i = 4'($urandom);
      m0_adr_i = $urandom; m0_dat_i = $urandom;
      m1_adr_i = $urandom; m1_dat_i = $urandom;
      s_stall_i = ($urandom % 4) == 0;
      s_dat_i   = $urandom;
      if (quiet > 0) begin
        quiet--;
        s_ack_i = 1'b0;
      end else begin
        if (($urandom % 40) == 0) quiet = 12;
        s_ack_i = (m_out > 0) && (($urandom % 3) == 0);
      end
      timeout_clr_i = ($urandom % 8) == 0;
      #2; cyc_end();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
